// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
//
// Instruction-fetch front end. Owns the program counter, issues single-word
// reads to instruction memory over a req/gnt + rvalid interface, and buffers
// {pc, instr} pairs for decode behind a valid/ready handshake. A redirect
// from the jump/branch unit flushes everything buffered or in flight and
// restarts fetch at the (word-aligned) target.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   jb_enable     redirect request, single-cycle pulse
//   jb_target_pc  redirect target address
//   imem_req      instruction memory read request
//   imem_addr     read address (word aligned)
//   imem_gnt      memory accepted the request this cycle
//   imem_rvalid   read data valid (in order, at least one cycle after gnt)
//   imem_rdata    instruction word
//   if_valid      {if_pc, if_instr} valid to decode
//   if_pc         pc of the presented instruction
//   if_instr      presented instruction
//   if_ready      decode accepts the head entry when if_valid & if_ready
//   misalign_err  one-cycle pulse after a redirect whose target[1:0] != 0
// ---------------------------------------------------------------------------
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jb_enable,
  input  logic [31:0] jb_target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // may issue a read for fetch_pc
    S_WAIT = 2'd1,  // one read outstanding, its data will be kept
    S_DROP = 2'd2   // one read outstanding, its data will be discarded
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state_reg;
  state_t             state_next;
  logic [31:0]        fetch_pc_reg;
  logic [31:0]        fetch_pc_next;
  logic [31:0]        req_pc_reg;     // pc of the read currently in flight
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic               misalign_reg;

  // Fetch buffer storage; not reset because the outputs are qualified by
  // the entry count.
  logic [31:0]        pc_mem    [FIFO_DEPTH];
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_sel;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic fifo_full;
  logic grant;
  logic push;
  logic pop;

  assign fifo_full = (count_reg == FULL_COUNT);

  // The request is a decode of registered state, which would read as 1
  // while reset is held (state resets to S_REQ with an empty buffer). It is
  // qualified with reset_n so the memory sees no request during reset and
  // the first request appears as soon as reset is released.
  assign imem_req  = reset_n && (state_reg == S_REQ) && !fifo_full;
  assign imem_addr = fetch_pc_reg;
  assign grant     = imem_req && imem_gnt;

  // A redirect in the same cycle voids both the incoming word and any pop:
  // the whole buffer is being discarded anyway.
  assign push = (state_reg == S_WAIT) && imem_rvalid && !jb_enable;
  assign pop  = if_valid && if_ready && !jb_enable;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;

    case (state_reg)
      S_REQ:   if (grant)       state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_next = S_REQ;
      S_DROP:  if (imem_rvalid) state_next = S_REQ;
      default:                  state_next = S_REQ;
    endcase

    if (grant) begin
      // Natural 32-bit wrap takes 0xFFFF_FFFC to 0.
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    // Redirect overrides everything above. Any read that is (or just became)
    // outstanding must still be retired, so it is tracked in S_DROP until
    // its rvalid arrives.
    if (jb_enable) begin
      fetch_pc_next = {jb_target_pc[31:2], 2'b00};
      case (state_reg)
        S_REQ:   state_next = grant       ? S_DROP : S_REQ;
        S_WAIT:  state_next = imem_rvalid ? S_REQ  : S_DROP;
        S_DROP:  state_next = imem_rvalid ? S_REQ  : S_DROP;
        default: state_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    if (jb_enable) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_REQ;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      misalign_reg <= jb_enable && (jb_target_pc[1:0] != 2'b00);
      if (grant) begin
        req_pc_reg <= fetch_pc_reg;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fetch buffer
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_sel[i]) begin
        pc_mem[i]    <= req_pc_reg;
        instr_mem[i] <= imem_rdata;
      end
    end
  end

  // Head entry is presented straight from the registered buffer, so a word
  // arriving on rvalid in cycle N is visible to decode in cycle N+1. The
  // data outputs read as zero whenever nothing is valid, which keeps stale
  // entries off the bus after a flush.
  assign if_valid     = (count_reg != '0);
  assign if_pc        = if_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
  assign if_instr     = if_valid ? instr_mem[rd_ptr_reg] : 32'd0;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

  logic        clk;
  logic        reset_n;
  logic        jb_enable;
  logic [31:0] jb_target_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_err;

  int n_cmp;
  int n_err;

  // Memory model controls
  logic        gnt_en;
  int          rv_delay;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;

  fetch_redirect_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .jb_enable    (jb_enable),
    .jb_target_pc (jb_target_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_ready     (if_ready),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: every word reads back as ~address. Grant and rvalid
  // for cycle k are decided at the falling edge inside cycle k; rvalid comes
  // rv_delay cycles after the grant cycle. Nothing is returned across reset.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!reset_n) begin
      pend_valid = 1'b0;
      imem_gnt   = 1'b0;
    end else begin
      if (pend_valid) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ~pend_addr;
          pend_valid  = 1'b0;
        end
      end
      imem_gnt = gnt_en;
      if (imem_req && gnt_en) begin
        pend_valid = 1'b1;
        pend_addr  = imem_addr;
        pend_cnt   = rv_delay;
      end
    end
  end

  // Observation/drive point: 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds reset for two cycles and releases it; the cycle in which it is
  // released is cycle 0, the next step() lands in cycle 1.
  task automatic do_reset();
    reset_n      = 1'b0;
    gnt_en       = 1'b0;
    if_ready     = 1'b0;
    jb_enable    = 1'b0;
    jb_target_pc = 32'd0;
    rv_delay     = 1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    gnt_en       = 1'b0;
    if_ready     = 1'b1;
    jb_enable    = 1'b0;
    jb_target_pc = 32'd0;
    step();
    step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %08h want 00000000", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %08h want 00000000", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %08h want 00000000", if_instr); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %0h want 0", misalign_err); end
    $display("reset: outputs checked while reset_n low");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b1;
    step(); // cycle 1: first request at RESET_PC
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req_c1: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL stream_addr_c1: got %08h want 00000000", imem_addr); end
    step(); // cycle 2: waiting, data returns
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_c2: got %0h want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stream_req_c2: got %0h want 0", imem_req); end
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(k * 4);
      step();
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid_%0d: got %0h want 1", k, if_valid); end
      n_cmp++; if (if_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc_%0d: got %08h want %08h", k, if_pc, exp_pc); end
      n_cmp++; if (if_instr !== ~exp_pc) begin n_err++; $display("FAIL stream_instr_%0d: got %08h want %08h", k, if_instr, ~exp_pc); end
      $display("stream: pc=%08h instr=%08h", if_pc, if_instr);
      step();
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_gap_%0d: got %0h want 0", k, if_valid); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b0;
    step(); step(); step(); // cycle 3: second request at 4
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL bp_req_c3: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL bp_addr_c3: got %08h want 00000004", imem_addr); end
    step(); step(); // cycle 5: two entries, request held low
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_c5: got %0h want 0", imem_req); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL bp_pc_c5: got %08h want 00000000", if_pc); end
    step(); step(); // cycle 7: still full
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_c7: got %0h want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c7: got %0h want 1", if_valid); end
    if_ready = 1'b1;
    step(); // cycle 8: second entry, fetch resumes at 8
    n_cmp++; if (if_pc !== 32'h4) begin n_err++; $display("FAIL bp_pc_c8: got %08h want 00000004", if_pc); end
    n_cmp++; if (if_instr !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL bp_instr_c8: got %08h want fffffffb", if_instr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL bp_req_c8: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_addr_c8: got %08h want 00000008", imem_addr); end
    step(); // cycle 9: drained
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_c9: got %0h want 0", if_valid); end
    step(); // cycle 10
    n_cmp++; if (if_pc !== 32'h8) begin n_err++; $display("FAIL bp_pc_c10: got %08h want 00000008", if_pc); end
    $display("backpressure: resumed pc=%08h", if_pc);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b0;
    rv_delay = 2;
    step(); step(); step(); step(); step(); // cycle 5: read of 4 outstanding
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rw_valid_c5: got %0h want 1", if_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req_c5: got %0h want 0", imem_req); end
    jb_enable    = 1'b1;
    jb_target_pc = 32'h0000_0100;
    step(); // cycle 6: flushed, stale rvalid arrives
    jb_enable = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rw_valid_c6: got %0h want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rw_req_c6: got %0h want 0", imem_req); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rw_misalign_c6: got %0h want 0", misalign_err); end
    step(); // cycle 7: fetch at target
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rw_req_c7: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rw_addr_c7: got %08h want 00000100", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rw_valid_c7: got %0h want 0", if_valid); end
    step(); step(); // cycle 9
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rw_valid_c9: got %0h want 0", if_valid); end
    step(); // cycle 10
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rw_valid_c10: got %0h want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h100) begin n_err++; $display("FAIL rw_pc_c10: got %08h want 00000100", if_pc); end
    n_cmp++; if (if_instr !== 32'hFFFF_FEFF) begin n_err++; $display("FAIL rw_instr_c10: got %08h want fffffeff", if_instr); end
    $display("redirect_wait: pc=%08h instr=%08h", if_pc, if_instr);
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b0;
    step(); step(); step(); step(); // cycle 4: head pc 0, rvalid for 4
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rp_pc_c4: got %08h want 00000000", if_pc); end
    if_ready     = 1'b1;
    jb_enable    = 1'b1;
    jb_target_pc = 32'h0000_0200;
    step(); // cycle 5
    jb_enable = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rp_valid_c5: got %0h want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rp_req_c5: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL rp_addr_c5: got %08h want 00000200", imem_addr); end
    step(); // cycle 6
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rp_valid_c6: got %0h want 0", if_valid); end
    step(); // cycle 7
    n_cmp++; if (if_pc !== 32'h200) begin n_err++; $display("FAIL rp_pc_c7: got %08h want 00000200", if_pc); end
    n_cmp++; if (if_instr !== 32'hFFFF_FDFF) begin n_err++; $display("FAIL rp_instr_c7: got %08h want fffffdff", if_instr); end
    step(); step(); // cycle 9
    n_cmp++; if (if_pc !== 32'h204) begin n_err++; $display("FAIL rp_pc_c9: got %08h want 00000204", if_pc); end
    $display("redirect_rvalid_pop: pc=%08h", if_pc);
  endtask

  task automatic test_redirect_on_grant();
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b1;
    rv_delay = 2;
    step(); // cycle 1: read of 0 granted, redirect in same cycle
    jb_enable    = 1'b1;
    jb_target_pc = 32'h0000_0400;
    step(); // cycle 2: draining the read of 0
    jb_enable = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rg_req_c2: got %0h want 0", imem_req); end
    step(); // cycle 3: its rvalid is discarded
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rg_req_c3: got %0h want 0", imem_req); end
    step(); // cycle 4
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rg_req_c4: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h400) begin n_err++; $display("FAIL rg_addr_c4: got %08h want 00000400", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rg_valid_c4: got %0h want 0", if_valid); end
    step(); step(); step(); // cycle 7
    n_cmp++; if (if_pc !== 32'h400) begin n_err++; $display("FAIL rg_pc_c7: got %08h want 00000400", if_pc); end
    $display("redirect_on_grant: pc=%08h", if_pc);
  endtask

  task automatic test_misalign();
    do_reset();
    gnt_en   = 1'b0;
    if_ready = 1'b1;
    step(); // cycle 1: request pending without grant
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL ma_err_c1: got %0h want 0", misalign_err); end
    jb_enable    = 1'b1;
    jb_target_pc = 32'h0000_0102;
    step(); // cycle 2
    jb_enable = 1'b0;
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL ma_err_c2: got %0h want 1", misalign_err); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL ma_req_c2: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL ma_addr_c2: got %08h want 00000100", imem_addr); end
    step(); // cycle 3
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL ma_err_c3: got %0h want 0", misalign_err); end
    gnt_en = 1'b1;
    step(); step(); step(); // cycle 6
    n_cmp++; if (if_pc !== 32'h100) begin n_err++; $display("FAIL ma_pc_c6: got %08h want 00000100", if_pc); end
    $display("misalign: fetched pc=%08h", if_pc);
  endtask

  task automatic test_reset_midop();
    do_reset();
    gnt_en   = 1'b1;
    if_ready = 1'b0;
    rv_delay = 2;
    step(); step(); step(); step(); step(); // cycle 5: 1 entry, read outstanding
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rm_valid_pre: got %0h want 1", if_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req: got %0h want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %08h want 00000000", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %0h want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc: got %08h want 00000000", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rm_instr: got %08h want 00000000", if_instr); end
    step(); step();
    reset_n = 1'b1;
    step(); // cycle 1 after release
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rm_req_rel: got %0h want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr_rel: got %08h want 00000000", imem_addr); end
    step(); step(); step(); // cycle 4
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rm_valid_c4: got %0h want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc_c4: got %08h want 00000000", if_pc); end
    $display("reset_midop: restarted pc=%08h", if_pc);
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_en   = 1'b0;
    if_ready = 1'b1;
    step(); // cycle 1
    jb_enable    = 1'b1;
    jb_target_pc = 32'hFFFF_FFFC;
    step(); // cycle 2
    jb_enable = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr_c2: got %08h want fffffffc", imem_addr); end
    gnt_en = 1'b1;
    step(); step(); step(); // cycle 5
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc_c5: got %08h want fffffffc", if_pc); end
    n_cmp++; if (if_instr !== 32'h0000_0003) begin n_err++; $display("FAIL wrap_instr_c5: got %08h want 00000003", if_instr); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr_c5: got %08h want 00000000", imem_addr); end
    step(); step(); // cycle 7
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc_c7: got %08h want 00000000", if_pc); end
    $display("wrap: pc after fffffffc=%08h", if_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    jb_enable    = 1'b0;
    jb_target_pc = 32'd0;
    if_ready     = 1'b0;
    gnt_en       = 1'b0;
    rv_delay     = 1;
    pend_valid   = 1'b0;
    pend_addr    = 32'd0;
    pend_cnt     = 0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_redirect_on_grant();
    test_misalign();
    test_reset_midop();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
